// File: rtl/alu_pkg.sv
// Shared constants, ALU opcodes and shifter mode encoding for the
// KGPminiRISC ALU slice.
package alu_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned EXT_W   = WIDTH + 1;

    localparam logic [OP_W-1:0] OP_PASS = 5'b00000;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00001;
    localparam logic [OP_W-1:0] OP_COMP = 5'b00101;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b10101;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00010;
    localparam logic [OP_W-1:0] OP_XOR  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SHLL = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHRL = 5'b01010;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01001;

    typedef enum logic [1:0] {
        SH_LEFT      = 2'd0,
        SH_RIGHT_LOG = 2'd1,
        SH_RIGHT_ARI = 2'd2
    } shift_mode_e;

endpackage

// File: rtl/alu_if.sv
// ALU operand/result bundle.
//   a, b, ALUsel, ALUop : operands and control, driven by the master
//   result, carry, zero, sign : registered outputs, driven by the slave (ALU)
interface alu_if;
    import alu_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ALUsel;
    logic [OP_W-1:0]  ALUop;
    logic             carry;
    logic             zero;
    logic             sign;
    logic [WIDTH-1:0] result;

    modport master (
        output a, b, ALUsel, ALUop,
        input  carry, zero, sign, result
    );

    modport slave (
        input  a, b, ALUsel, ALUop,
        output carry, zero, sign, result
    );

endinterface

// File: rtl/alu_shifter.sv
// Combinational 5-stage barrel shifter with shift-out bit.
//   a         : value to shift
//   shamt     : shift amount (0..31)
//   mode      : left / right-logical / right-arithmetic
//   value     : shifted result
//   shift_out : last bit shifted out (0 when shamt == 0)
module alu_shifter
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_mode_e        mode,
    output logic [WIDTH-1:0]   value,
    output logic               shift_out
);

    // One guard bit catches the shift-out: bit 32 for left, bit 0 for right.
    logic [EXT_W-1:0] v;

    always_comb begin
        v = (mode == SH_LEFT) ? {1'b0, a} : {a, 1'b0};
        for (int i = 0; i < int'(SHAMT_W); i++) begin
            if (shamt[i]) begin
                case (mode)
                    SH_LEFT:      v = v << (1 << i);
                    SH_RIGHT_ARI: v = EXT_W'($signed(v) >>> (1 << i));
                    default:      v = v >> (1 << i);
                endcase
            end
        end
    end

    always_comb begin
        if (mode == SH_LEFT) begin
            value     = v[WIDTH-1:0];
            shift_out = v[WIDTH];
        end else begin
            value     = v[WIDTH:1];
            shift_out = v[0];
        end
    end

endmodule

// File: rtl/alu_unit.sv
// 32-bit ALU with registered result and carry/zero/sign flags (1-cycle latency).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_if slave -- a, b, ALUsel, ALUop in; result, carry, zero, sign out
module alu_unit
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);

    logic [WIDTH-1:0] opb;
    logic [EXT_W-1:0] sum;
    logic [EXT_W-1:0] diff;
    logic [EXT_W-1:0] neg;
    shift_mode_e      sh_mode;
    logic [WIDTH-1:0] sh_value;
    logic             sh_out;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             sign_q;

    // Operand B: constant one for increment / shift-by-one forms.
    assign opb = bus.ALUsel ? WIDTH'(1) : bus.b;

    // 33-bit adders so the carry-out falls out as the top bit.
    always_comb begin
        sum  = {1'b0, bus.a} + {1'b0, opb};
        diff = {1'b0, bus.a} + {1'b0, ~opb} + EXT_W'(1);
        neg  = {1'b0, ~opb} + EXT_W'(1);
    end

    // Shifter direction from opcode.
    always_comb begin
        sh_mode = SH_RIGHT_LOG;
        if (bus.ALUop == OP_SHLL) begin
            sh_mode = SH_LEFT;
        end else if (bus.ALUop == OP_SHRA) begin
            sh_mode = SH_RIGHT_ARI;
        end
    end

    alu_shifter u_shifter (
        .a         (bus.a),
        .shamt     (opb[SHAMT_W-1:0]),
        .mode      (sh_mode),
        .value     (sh_value),
        .shift_out (sh_out)
    );

    // Next result/carry select; unknown opcodes behave as PASS.
    always_comb begin
        result_d = bus.a;
        carry_d  = 1'b0;
        case (bus.ALUop)
            OP_ADD:  {carry_d, result_d} = sum;
            OP_SUB:  {carry_d, result_d} = diff;
            OP_COMP: {carry_d, result_d} = neg;
            OP_AND:  result_d = bus.a & opb;
            OP_XOR:  result_d = bus.a ^ opb;
            OP_SHLL, OP_SHRL, OP_SHRA: begin
                result_d = sh_value;
                carry_d  = sh_out;
            end
            default: begin
                result_d = bus.a;
                carry_d  = 1'b0;
            end
        endcase
    end

    // Output register; flags derived from the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= (result_d == '0);
            sign_q   <= result_d[WIDTH-1];
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.zero   = zero_q;
    assign bus.sign   = sign_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: directed vectors push expected responses,
// a monitor pops and compares one cycle after each op is applied.
module tb_alu_unit;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] r;
        logic        c;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    alu_if bus ();

    alu_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare {carry, zero, sign, result}.
    task automatic check(input string nm, input logic [34:0] got, input logic [34:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got c=%b z=%b s=%b r=%h, want c=%b z=%b s=%b r=%h",
                     nm, got[34], got[33], got[32], got[31:0],
                     exp[34], exp[33], exp[32], exp[31:0]);
        end
    endtask

    function automatic logic [34:0] pack_exp(input logic [31:0] r, input logic c);
        return {c, (r == 32'd0), r[31], r};
    endfunction

    function automatic logic [34:0] pack_dut();
        return {bus.carry, bus.zero, bus.sign, bus.result};
    endfunction

    // Apply one op at the falling edge and queue its expected response.
    task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic sel, input logic [4:0] op,
                         input logic [31:0] er, input logic ec);
        exp_t e;
        @(negedge clk);
        bus.a      = a;
        bus.b      = b;
        bus.ALUsel = sel;
        bus.ALUop  = op;
        e.name = nm;
        e.r    = er;
        e.c    = ec;
        sb.push_back(e);
    endtask

    // Monitor: the op sampled at each rising edge is visible just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, pack_dut(), pack_exp(e.r, e.c));
            end
        end
    end

    localparam logic [31:0] A0 = 32'hFFFC1FFF;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n      = 1'b0;
        bus.a      = 32'hDEADBEEF;
        bus.b      = 32'h12345678;
        bus.ALUsel = 1'b0;
        bus.ALUop  = OP_ADD;

        #2;
        check("reset_initial", pack_dut(), 35'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", pack_dut(), 35'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic
        issue("add",  A0, 32'd7, 1'b0, OP_ADD,  32'hFFFC2006, 1'b0);
        issue("sub",  A0, 32'd7, 1'b0, OP_SUB,  32'hFFFC1FF8, 1'b1);
        issue("comp", A0, 32'd7, 1'b0, OP_COMP, 32'hFFFFFFF9, 1'b0);
        issue("pass", A0, 32'd7, 1'b0, OP_PASS, 32'hFFFC1FFF, 1'b0);
        // Logic
        issue("and",  A0, 32'd7, 1'b0, OP_AND,  32'h00000007, 1'b0);
        issue("xor",  A0, 32'd7, 1'b0, OP_XOR,  32'hFFFC1FF8, 1'b0);
        // Shifts
        issue("shll", A0, 32'd7, 1'b0, OP_SHLL, 32'hFE0FFF80, 1'b1);
        issue("shrl", A0, 32'd7, 1'b0, OP_SHRL, 32'h01FFF83F, 1'b1);
        issue("shra", A0, 32'd7, 1'b0, OP_SHRA, 32'hFFFFF83F, 1'b1);
        // ALUsel = 1 (B = 1)
        issue("add_sel",  A0, 32'd7, 1'b1, OP_ADD,  32'hFFFC2000, 1'b0);
        issue("shll_sel", A0, 32'd7, 1'b1, OP_SHLL, 32'hFFF83FFE, 1'b1);
        issue("shra_sel", A0, 32'd7, 1'b1, OP_SHRA, 32'hFFFE0FFF, 1'b1);
        issue("shrl_sel", A0, 32'd7, 1'b1, OP_SHRL, 32'h7FFE0FFF, 1'b1);

        // Mid-stream asynchronous reset discards the in-flight op.
        @(negedge clk);
        bus.a      = 32'h12345678;
        bus.b      = 32'd3;
        bus.ALUsel = 1'b0;
        bus.ALUop  = OP_ADD;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_async", pack_dut(), 35'd0);
        @(posedge clk);
        #1;
        check("reset_mid_hold", pack_dut(), 35'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Boundaries
        issue("sub_eq",    32'd5,        32'd5,  1'b0, OP_SUB,   32'h00000000, 1'b1);
        issue("sub_borrow",32'd0,        32'd1,  1'b0, OP_SUB,   32'hFFFFFFFF, 1'b0);
        issue("add_wrap",  32'hFFFFFFFF, 32'd1,  1'b0, OP_ADD,   32'h00000000, 1'b1);
        issue("shll_zero", A0,           32'd32, 1'b0, OP_SHLL,  A0,           1'b0);
        issue("shra_zero", A0,           32'd32, 1'b0, OP_SHRA,  A0,           1'b0);
        issue("comp_zero", A0,           32'd0,  1'b0, OP_COMP,  32'h00000000, 1'b1);
        issue("undef_op",  A0,           32'd7,  1'b0, 5'b11111, A0,           1'b0);
        issue("shrl_31",   32'h80000000, 32'd31, 1'b0, OP_SHRL,  32'h00000001, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
